lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and request legality helper for lsu_ctrl.
// Macro LSU_MISALIGNED_EN adds the SECOND state for word-crossing accesses.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef LSU_MISALIGNED_EN
    SECOND = 2'd2,
`endif
    RESP   = 2'd3
  } lsu_state_e;

  // Encodings with no defined access, including unsigned-load codes used for a store.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    logic v_bad;
    case (f3)
      F3_B, F3_H, F3_W: v_bad = 1'b0;
      F3_BU, F3_HU:     v_bad = is_store;
      default:          v_bad = 1'b1;
    endcase
    return v_bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane enables, store data positioning and load extract/extension.
// Works on a 64-bit window (low word, high word) so word-crossing accesses fall out naturally.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata_lo,
  input  logic [DATA_W-1:0] i_rdata_hi,
  output logic [3:0]        o_we_lo_c,
  output logic [3:0]        o_we_hi_c,
  output logic [DATA_W-1:0] o_wdata_lo_c,
  output logic [DATA_W-1:0] o_wdata_hi_c,
  output logic [DATA_W-1:0] o_rdata_c,
  output logic              o_misaligned_c,
  output logic              o_cross_c
);

  logic [7:0]  w_mask8;
  logic [7:0]  w_lanes;
  logic [63:0] w_st64;
  logic [63:0] w_ld64;
  logic [31:0] w_raw;
  logic [4:0]  w_shamt;

  // Lane mask by access size, then positioned by byte offset (little-endian).
  always_comb begin
    w_mask8 = 8'h00;
    case (i_funct3[1:0])
      2'b00:   w_mask8 = 8'h01;
      2'b01:   w_mask8 = 8'h03;
      2'b10:   w_mask8 = 8'h0F;
      default: w_mask8 = 8'h00;
    endcase
    w_lanes   = w_mask8 << i_off;
    o_we_lo_c = w_lanes[3:0];
    o_we_hi_c = w_lanes[7:4];
  end

  // Store data shifted into lanes across the two-word window.
  always_comb begin
    w_shamt      = {i_off, 3'b000};
    w_st64       = {32'd0, i_wdata} << w_shamt;
    o_wdata_lo_c = w_st64[31:0];
    o_wdata_hi_c = w_st64[63:32];
  end

  // Load data right-aligned from the window, then sign/zero extended.
  always_comb begin
    w_ld64 = {i_rdata_hi, i_rdata_lo} >> w_shamt;
    w_raw  = w_ld64[31:0];
    case (i_funct3)
      F3_B:    o_rdata_c = {{24{w_raw[7]}}, w_raw[7:0]};
      F3_H:    o_rdata_c = {{16{w_raw[15]}}, w_raw[15:0]};
      F3_W:    o_rdata_c = w_raw;
      F3_BU:   o_rdata_c = {24'd0, w_raw[7:0]};
      F3_HU:   o_rdata_c = {16'd0, w_raw[15:0]};
      default: o_rdata_c = '0;
    endcase
  end

  // Alignment classification: misaligned halfword/word, and whether it spans two words.
  always_comb begin
    o_misaligned_c = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
    o_cross_c      = ((i_funct3[1:0] == 2'b01) && (i_off == 2'b11)) ||
                     ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit between a CPU request port and a word memory.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two memory cycles;
// otherwise every misaligned access is rejected with resp_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dwdata,
  output logic [3:0]        we,
  input  logic [DATA_W-1:0] drdata
);

  lsu_state_e        r_state, w_nstate;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic              r_is_store;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
`ifdef LSU_MISALIGNED_EN
  logic              r_cross;
  logic [DATA_W-1:0] r_lo;
`endif

  logic              r_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [ADDR_W-1:0] r_daddr;
  logic [DATA_W-1:0] r_dwdata;
  logic [3:0]        r_we;

  logic              w_ready_n;
  logic              w_resp_valid_n;
  logic              w_resp_err_n;
  logic [DATA_W-1:0] w_resp_rdata_n;
  logic [ADDR_W-1:0] w_daddr_n;
  logic [DATA_W-1:0] w_dwdata_n;
  logic [3:0]        w_we_n;

  logic              w_idle;
  logic [2:0]        w_f3;
  logic [1:0]        w_off;
  logic [DATA_W-1:0] w_wd;
  logic [DATA_W-1:0] w_rd_lo;
  logic [DATA_W-1:0] w_rd_hi;
  logic [3:0]        w_we_lo, w_we_hi;
  logic [DATA_W-1:0] w_wdata_lo, w_wdata_hi;
  logic [DATA_W-1:0] w_rdata_ext;
  logic              w_misal;
  logic              w_cross;
  logic              w_req_err;

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign daddr      = r_daddr;
  assign dwdata     = r_dwdata;
  assign we         = r_we;

  // In IDLE the aligner looks at the incoming request; afterwards at the captured one.
  assign w_idle = (r_state == IDLE);
  assign w_f3   = w_idle ? req_funct3 : r_funct3;
  assign w_off  = w_idle ? req_addr[1:0] : r_addr_off();
  assign w_wd   = w_idle ? req_wdata : r_wdata;

  function automatic logic [1:0] r_addr_off();
    return r_off;
  endfunction

`ifdef LSU_MISALIGNED_EN
  // In SECOND the window is the saved low word plus the word now on drdata.
  assign w_rd_lo   = (r_state == SECOND) ? r_lo : drdata;
  assign w_rd_hi   = (r_state == SECOND) ? drdata : '0;
  assign w_req_err = f3_illegal(req_funct3, req_we);
`else
  logic w_unused;
  assign w_rd_lo   = drdata;
  assign w_rd_hi   = '0;
  assign w_req_err = f3_illegal(req_funct3, req_we) || w_misal;
  assign w_unused  = ^{w_cross, w_we_hi, w_wdata_hi};
`endif

  lsu_align u_align (
    .i_funct3       (w_f3),
    .i_off          (w_off),
    .i_wdata        (w_wd),
    .i_rdata_lo     (w_rd_lo),
    .i_rdata_hi     (w_rd_hi),
    .o_we_lo_c      (w_we_lo),
    .o_we_hi_c      (w_we_hi),
    .o_wdata_lo_c   (w_wdata_lo),
    .o_wdata_hi_c   (w_wdata_hi),
    .o_rdata_c      (w_rdata_ext),
    .o_misaligned_c (w_misal),
    .o_cross_c      (w_cross)
  );

  // State, captured request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_off        <= '0;
      r_funct3     <= '0;
      r_is_store   <= 1'b0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      r_cross      <= 1'b0;
      r_lo         <= '0;
`endif
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_daddr      <= '0;
      r_dwdata     <= '0;
      r_we         <= '0;
    end else begin
      r_state      <= w_nstate;
      r_ready      <= w_ready_n;
      r_resp_valid <= w_resp_valid_n;
      r_resp_err   <= w_resp_err_n;
      r_resp_rdata <= w_resp_rdata_n;
      r_daddr      <= w_daddr_n;
      r_dwdata     <= w_dwdata_n;
      r_we         <= w_we_n;
      if (w_idle && req_valid) begin
        r_off      <= req_addr[1:0];
        r_funct3   <= req_funct3;
        r_is_store <= req_we;
        r_wdata    <= req_wdata;
        r_err      <= w_req_err;
`ifdef LSU_MISALIGNED_EN
        r_cross    <= w_cross;
`endif
      end
`ifdef LSU_MISALIGNED_EN
      if ((r_state == ACCESS) && r_cross && !r_err) begin
        r_lo <= drdata;
      end
`endif
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    w_nstate       = r_state;
    w_ready_n      = 1'b0;
    w_resp_valid_n = 1'b0;
    w_resp_err_n   = 1'b0;
    w_resp_rdata_n = '0;
    w_daddr_n      = '0;
    w_dwdata_n     = '0;
    w_we_n         = '0;
    case (r_state)
      IDLE: begin
        w_ready_n = 1'b1;
        if (req_valid) begin
          w_nstate  = ACCESS;
          w_ready_n = 1'b0;
          if (!w_req_err) begin
            w_daddr_n = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we) begin
              w_we_n     = w_we_lo;
              w_dwdata_n = w_wdata_lo;
            end
          end
        end
      end
      ACCESS: begin
`ifdef LSU_MISALIGNED_EN
        if (r_cross && !r_err) begin
          w_nstate  = SECOND;
          w_daddr_n = r_daddr + ADDR_W'(4);
          if (r_is_store) begin
            w_we_n     = w_we_hi;
            w_dwdata_n = w_wdata_hi;
          end
        end else
`endif
        begin
          w_nstate       = RESP;
          w_resp_valid_n = 1'b1;
          w_resp_err_n   = r_err;
          if (!r_err && !r_is_store) begin
            w_resp_rdata_n = w_rdata_ext;
          end
        end
      end
`ifdef LSU_MISALIGNED_EN
      SECOND: begin
        w_nstate       = RESP;
        w_resp_valid_n = 1'b1;
        if (!r_is_store) begin
          w_resp_rdata_n = w_rdata_ext;
        end
      end
`endif
      RESP: begin
        w_nstate  = IDLE;
        w_ready_n = 1'b1;
      end
      default: begin
        w_nstate  = IDLE;
        w_ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with a small byte-enabled word memory.
// Expectations follow LSU_MISALIGNED_EN when it is defined for the build.
module tb_lsu_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  logic [31:0] mem [16];
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_data;

  int n_tests;
  int n_fail;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .we         (we),
    .drdata     (drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign drdata = mem[daddr[5:2]];

  // Memory: backdoor preload or byte-enabled write from the DUT.
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[daddr[5:2]][8*b +: 8] <= dwdata[8*b +: 8];
    end
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    bd_idx = idx; bd_data = data; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Waits (bounded) for req_ready, presents one request, returns #1 into cycle N+1.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
    end
    req_we = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", resp_valid); end
    n_tests++; if (resp_err !== 1'b0)   begin n_fail++; $display("FAIL rst_err: got %0b want 0", resp_err); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    n_tests++; if (we !== 4'h0)         begin n_fail++; $display("FAIL rst_we: got %h want 0", we); end
    n_tests++; if (daddr !== 32'h0)     begin n_fail++; $display("FAIL rst_daddr: got %h want 0", daddr); end
    n_tests++; if (dwdata !== 32'h0)    begin n_fail++; $display("FAIL rst_dwdata: got %h want 0", dwdata); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3   [3] = '{3'd0, 3'd4, 3'd1};
    logic [31:0] addr [3] = '{32'h0B, 32'h0B, 32'h0A};
    logic [31:0] exp  [3] = '{32'hFFFFFF87, 32'h00000087, 32'hFFFF8765};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, f3[i], addr[i], 32'h0);
      n_tests++; if (daddr !== 32'h08 || we !== 4'h0) begin n_fail++;
        $display("FAIL load%0d_access: daddr=%h we=%h want 00000008/0", i, daddr, we); end
      @(posedge clk); #1;
      n_tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp[i]) begin n_fail++;
        $display("FAIL load%0d_resp: valid=%0b err=%0b rdata=%h want 1/0/%h", i, resp_valid, resp_err, resp_rdata, exp[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_misaligned();
    issue(1'b0, 3'd2, 32'h09, 32'h0);
`ifdef LSU_MISALIGNED_EN
    n_tests++; if (daddr !== 32'h08 || we !== 4'h0) begin n_fail++;
      $display("FAIL lw09_first: daddr=%h we=%h want 00000008/0", daddr, we); end
    @(posedge clk); #1;
    n_tests++; if (daddr !== 32'h0C || resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL lw09_second: daddr=%h valid=%0b want 0000000c/0", daddr, resp_valid); end
    @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h44876543) begin n_fail++;
      $display("FAIL lw09_resp: valid=%0b err=%0b rdata=%h want 1/0/44876543", resp_valid, resp_err, resp_rdata); end
`else
    n_tests++; if (we !== 4'h0 || daddr !== 32'h0) begin n_fail++;
      $display("FAIL lw09_skip: we=%h daddr=%h want 0/0", we, daddr); end
    @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || we !== 4'h0) begin n_fail++;
      $display("FAIL lw09_err: valid=%0b err=%0b rdata=%h we=%h want 1/1/0/0", resp_valid, resp_err, resp_rdata, we); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic        w  [2] = '{1'b0, 1'b1};
    logic [2:0]  f3 [2] = '{3'd3, 3'd4};
    for (int i = 0; i < 2; i++) begin
      issue(w[i], f3[i], 32'h10, 32'hFFFFFFFF);
      n_tests++; if (we !== 4'h0 || daddr !== 32'h0 || dwdata !== 32'h0) begin n_fail++;
        $display("FAIL illegal%0d_skip: we=%h daddr=%h dwdata=%h want 0", i, we, daddr, dwdata); end
      @(posedge clk); #1;
      n_tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin n_fail++;
        $display("FAIL illegal%0d_resp: valid=%0b err=%0b rdata=%h want 1/1/0", i, resp_valid, resp_err, resp_rdata); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    issue(1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
    n_tests++; if (daddr !== 32'h08 || we !== 4'hF || dwdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin n_fail++;
      $display("FAIL sw_access: daddr=%h we=%h dwdata=%h ready=%0b want 00000008/f/deadbeef/0", daddr, we, dwdata, req_ready); end
    @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || we !== 4'h0 || daddr !== 32'h0) begin n_fail++;
      $display("FAIL sw_resp: valid=%0b err=%0b rdata=%h we=%h daddr=%h want 1/0/0/0/0", resp_valid, resp_err, resp_rdata, we, daddr); end
    n_tests++; if (mem[2] !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL sw_mem: got %h want deadbeef", mem[2]); end
    @(posedge clk); #1;
  endtask

  task automatic test_sb();
    issue(1'b1, 3'd0, 32'h0D, 32'h000000AA);
    n_tests++; if (daddr !== 32'h0C || we !== 4'b0010 || dwdata !== 32'h0000AA00) begin n_fail++;
      $display("FAIL sb_access: daddr=%h we=%h dwdata=%h want 0000000c/2/0000aa00", daddr, we, dwdata); end
    @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b1 || mem[3] !== 32'h1122AA44) begin n_fail++;
      $display("FAIL sb_resp: valid=%0b mem=%h want 1/1122aa44", resp_valid, mem[3]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    preload(4'd8, 32'h55AA55AA);
    issue(1'b1, 3'd2, 32'h20, 32'h12345678);
    n_tests++; if (we !== 4'hF) begin n_fail++; $display("FAIL rmid_pre: we=%h want f", we); end
    reset = 1'b1;
    #1;
    n_tests++; if (we !== 4'h0 || daddr !== 32'h0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rmid_async: we=%h daddr=%h ready=%0b valid=%0b want 0/0/1/0", we, daddr, req_ready, resp_valid); end
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1 || we !== 4'h0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_noresp: activity=%0b want 0", seen); end
    n_tests++; if (mem[8] !== 32'h55AA55AA) begin n_fail++; $display("FAIL rmid_mem: got %h want 55aa55aa", mem[8]); end
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h08; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_access: got %0b want 0", req_ready); end
    req_funct3 = 3'd4; req_addr = 32'h0D;
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL b2b_resp1: ready=%0b valid=%0b rdata=%h want 0/1/deadbeef", req_ready, resp_valid, resp_rdata); end
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle: ready=%0b valid=%0b want 1/0", req_ready, resp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++; if (daddr !== 32'h0C || req_ready !== 1'b0) begin n_fail++;
      $display("FAIL b2b_second_accept: daddr=%h ready=%0b want 0000000c/0", daddr, req_ready); end
    @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000AA) begin n_fail++;
      $display("FAIL b2b_resp2: valid=%0b rdata=%h want 1/000000aa", resp_valid, resp_rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    bd_we = 1'b0; bd_idx = 4'd0; bd_data = 32'h0;
    test_reset();
    preload(4'd2, 32'h87654321);
    preload(4'd3, 32'h11223344);
    test_loads();
    test_misaligned();
    test_illegal();
    test_sw();
    test_sb();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
